// File: rtl/nonce_tx_scheduler.sv
// nonce_tx_scheduler: gathers golden nonces from the hasher array and
// arbitrates them round-robin into a small FIFO. A three-state FSM then
// feeds each nonce to serial_transmit as one 32-bit word over the
// send/busy handshake. Drops caused by overruns are counted, and the
// count saturates at 255.
// Optional feature: define NONCE_FLUSH_ON_LOAD_EN to discard all queued
// and pending nonces when load_flag toggles (new work loaded).
module nonce_tx_scheduler #(
  parameter int NUM_HASHERS = 6,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_HASHERS-1:0]          nonce_valid,
  input  logic [32*NUM_HASHERS-1:0]       nonce_in,
  input  logic                            load_flag,
  input  logic                            tx_busy,
  output logic                            tx_send,
  output logic [31:0]                     tx_word,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [7:0]                      drop_count,
  output logic                            idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (NUM_HASHERS > 1) ? $clog2(NUM_HASHERS) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_t;

  // Per-hasher capture slots
  logic [NUM_HASHERS-1:0] pending_reg;
  logic [31:0]            hold_reg [NUM_HASHERS];
  logic [NUM_HASHERS-1:0] drain;
  logic [NUM_HASHERS-1:0] drop;

  // Arbitration
  logic [PW-1:0]          rr_ptr_reg;
  logic [PW-1:0]          winner;
  logic                   winner_valid;
  logic                   push;

  // FIFO
  logic [31:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_reg;
  logic [AW-1:0]          rd_ptr_reg;
  logic [CW-1:0]          count_reg;
  logic                   fifo_full;
  logic                   pop;

  // TX FSM
  tx_state_t              state_reg;
  logic [1:0]             wait_cnt_reg;

  // Drop accounting
  logic [8:0]             drop_sum;
  logic [8:0]             drop_total;

  logic                   flush;

`ifdef NONCE_FLUSH_ON_LOAD_EN
  logic load_flag_reg;

  // Edge-detect copy of load_flag; reset re-samples it so no flush fires on exit
  always_ff @(posedge clk) begin
    load_flag_reg <= load_flag;
  end

  assign flush = load_flag ^ load_flag_reg;
`else
  logic unused_load_flag;
  assign unused_load_flag = load_flag;
  assign flush = 1'b0;
`endif

  assign fifo_full = (count_reg == FULL_COUNT);

  // The head is sent only from IDLE with the transmitter free; a flush
  // cycle sends nothing because the queue is being discarded.
  assign pop  = (state_reg == IDLE) && (count_reg != '0) && !tx_busy && !flush;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = winner_valid && (!fifo_full || pop) && !flush;

  // Round-robin pick: first pending slot at or after rr_ptr
  always_comb begin : arbiter
    int idx;
    winner_valid = 1'b0;
    winner       = '0;
    idx          = 0;
    for (int k = 0; k < NUM_HASHERS; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_HASHERS) idx = idx - NUM_HASHERS;
      if (!winner_valid && pending_reg[idx]) begin
        winner_valid = 1'b1;
        winner       = PW'(idx);
      end
    end
  end

  // A strobe into a slot that is still occupied and not leaving is lost
  generate
    for (genvar gi = 0; gi < NUM_HASHERS; gi++) begin : g_slot
      assign drain[gi] = push && (winner == PW'(gi));
      assign drop[gi]  = nonce_valid[gi] && pending_reg[gi] && !drain[gi] && !flush;
    end
  endgenerate

  // Capture strobes into slots; a slot drained this cycle can refill at once
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_HASHERS; i++) begin
      if (reset || flush) begin
        pending_reg[i] <= 1'b0;
      end else if (nonce_valid[i] && (!pending_reg[i] || drain[i])) begin
        pending_reg[i] <= 1'b1;
        hold_reg[i]    <= nonce_in[32*i +: 32];
      end else if (drain[i]) begin
        pending_reg[i] <= 1'b0;
      end
    end
  end

  // Advance the round-robin pointer past each winner
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= '0;
    end else if (push) begin
      rr_ptr_reg <= (int'(winner) == NUM_HASHERS - 1) ? '0 : winner + 1'b1;
    end
  end

  // Total drops this cycle
  always_comb begin
    drop_sum = '0;
    for (int i = 0; i < NUM_HASHERS; i++) begin
      drop_sum = drop_sum + {8'd0, drop[i]};
    end
  end

  assign drop_total = {1'b0, drop_count} + drop_sum;

  // Saturating drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else begin
      drop_count <= (drop_total > 9'd255) ? 8'd255 : drop_total[7:0];
    end
  end

  // FIFO storage write port (no reset, block-RAM friendly)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= hold_reg[winner];
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // TX sequencer: hand a word to serial_transmit and track its busy cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      tx_send      <= 1'b0;
      tx_word      <= '0;
      wait_cnt_reg <= '0;
    end else begin
      tx_send <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            tx_word      <= mem[rd_ptr_reg];
            tx_send      <= 1'b1;
            wait_cnt_reg <= '0;
            state_reg    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // Busy never seen after 4 cycles: treat the word as sent
          if (tx_busy) begin
            state_reg <= WAIT_DONE;
          end else if (wait_cnt_reg == 2'd3) begin
            state_reg <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign fifo_count = count_reg;
  assign idle       = (pending_reg == '0) && (count_reg == '0) && (state_reg == IDLE);

endmodule

// File: tb/tb_nonce_tx_scheduler.sv
// tb_nonce_tx_scheduler: scoreboard bench for nonce_tx_scheduler with a
// simple serial_transmit busy model. Expected words are queued when
// stimulus is driven and compared whenever tx_send fires.
module tb_nonce_tx_scheduler;

  localparam int NH = 6;
  localparam int FD = 4;
  localparam int BYTE_CYCLES = 7;

  logic            clk;
  logic            reset;
  logic [NH-1:0]   nonce_valid;
  logic [32*NH-1:0] nonce_in;
  logic            load_flag;
  logic            tx_busy;
  logic            tx_send;
  logic [31:0]     tx_word;
  logic [2:0]      fifo_count;
  logic [7:0]      drop_count;
  logic            idle;

  logic            hold_busy;
  logic            model_busy;
  int              busy_left;

  int              errors;
  int              checks;
  int              sends;
  logic            prev_send;
  logic [31:0]     exp_q [$];

  nonce_tx_scheduler #(.NUM_HASHERS(NH), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .reset      (reset),
    .nonce_valid(nonce_valid),
    .nonce_in   (nonce_in),
    .load_flag  (load_flag),
    .tx_busy    (tx_busy),
    .tx_send    (tx_send),
    .tx_word    (tx_word),
    .fifo_count (fifo_count),
    .drop_count (drop_count),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // serial_transmit stand-in: busy rises the edge after send, lasts BYTE_CYCLES
  always @(posedge clk) begin
    if (tx_send) begin
      model_busy <= 1'b1;
      busy_left  <= BYTE_CYCLES;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) model_busy <= 1'b0;
    end
  end

  assign tx_busy = model_busy | hold_busy;

  // One clock; samples 1 time unit after the edge and scores any send
  task automatic step();
    logic [31:0] exp_w;
    @(posedge clk);
    #1;
    if (tx_send) begin
      sends++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_send: got word %08h, required no send", tx_word);
      end else begin
        exp_w = exp_q.pop_front();
        if (tx_word !== exp_w) begin
          errors++;
          $display("FAIL tx_word: got %08h, required %08h", tx_word, exp_w);
        end else begin
          $display("send word %08h ok", tx_word);
        end
      end
      checks++;
      if (prev_send === 1'b1) begin
        errors++;
        $display("FAIL send_width: tx_send high two cycles, required one");
      end
    end
    prev_send = tx_send;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Advance until idle with transmitter quiet, bounded
  task automatic wait_idle(input int max_cycles, input string tag);
    bit done;
    done = 0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      step();
      if (idle && !tx_busy) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: idle=%0b busy=%0b, required idle within %0d cycles",
               tag, idle, tx_busy, max_cycles);
    end
  endtask

  task automatic strobe(input logic [NH-1:0] mask, input logic [31:0] base, input bit expect_tx);
    for (int i = 0; i < NH; i++) begin
      if (mask[i]) begin
        nonce_in[32*i +: 32] = base + 32'(i);
        if (expect_tx) exp_q.push_back(base + 32'(i));
      end
    end
    nonce_valid = mask;
    step();
    nonce_valid = '0;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end else begin
      $display("check %s = %0h ok", name, got);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_val("reset_tx_send", 32'(tx_send), 32'd0);
    check_val("reset_tx_word", tx_word, 32'd0);
    check_val("reset_fifo_count", 32'(fifo_count), 32'd0);
    check_val("reset_drop_count", 32'(drop_count), 32'd0);
    check_val("reset_idle", 32'(idle), 32'd1);
  endtask

  task automatic test_single();
    do_reset();
    sends = 0;
    nonce_in[32*2 +: 32] = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    nonce_valid = 6'b000100;
    step();
    nonce_valid = '0;
    step();
    check_val("single_no_early_send", 32'(tx_send), 32'd0);
    check_val("single_fifo_after_push", 32'(fifo_count), 32'd1);
    step();
    check_val("single_send_n2", 32'(tx_send), 32'd1);
    check_val("single_word_n2", tx_word, 32'hDEADBEEF);
    check_val("single_fifo_after_pop", 32'(fifo_count), 32'd0);
    wait_idle(100, "single");
    check_val("single_idle", 32'(idle), 32'd1);
    check_val("single_sends", 32'(sends), 32'd1);
  endtask

  task automatic test_round_robin();
    do_reset();
    sends = 0;
    strobe(6'b111111, 32'h1000, 1'b1);
    wait_idle(400, "rr");
    check_val("rr_sends", 32'(sends), 32'd6);
    check_val("rr_drop_count", 32'(drop_count), 32'd0);
    check_val("rr_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic test_capture_on_drain();
    hold_busy = 1'b1;
    do_reset();
    sends = 0;
    strobe(6'b000001, 32'h3000, 1'b1);
    strobe(6'b000001, 32'h3001, 1'b1);
    step();
    check_val("drain_capture_drops", 32'(drop_count), 32'd0);
    check_val("drain_capture_fifo", 32'(fifo_count), 32'd2);
    hold_busy = 1'b0;
    wait_idle(200, "drain");
    check_val("drain_capture_sends", 32'(sends), 32'd2);
  endtask

  task automatic test_overrun();
    hold_busy = 1'b1;
    do_reset();
    sends = 0;
    strobe(6'b001111, 32'h2000, 1'b1);
    for (int c = 0; c < 6; c++) step();
    strobe(6'b000001, 32'h2004, 1'b1);
    strobe(6'b000001, 32'hBAD1, 1'b0);
    strobe(6'b000001, 32'hBAD2, 1'b0);
    check_val("overrun_drop_count", 32'(drop_count), 32'd2);
    check_val("overrun_fifo_count", 32'(fifo_count), 32'd4);
    hold_busy = 1'b0;
    wait_idle(400, "overrun");
    check_val("overrun_sends", 32'(sends), 32'd5);
    check_val("overrun_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic test_saturation();
    hold_busy = 1'b1;
    do_reset();
    strobe(6'b111111, 32'h6000, 1'b0);
    for (int c = 0; c < 6; c++) step();
    strobe(6'b111111, 32'h6100, 1'b0);
    check_val("sat_partial_drops", 32'(drop_count), 32'd2);
    strobe(6'b111111, 32'h6200, 1'b0);
    check_val("sat_multi_drops", 32'(drop_count), 32'd8);
    for (int c = 0; c < 50; c++) strobe(6'b111111, 32'h6300, 1'b0);
    check_val("sat_255", 32'(drop_count), 32'd255);
    for (int c = 0; c < 3; c++) strobe(6'b111111, 32'h6400, 1'b0);
    check_val("sat_stays_255", 32'(drop_count), 32'd255);
    do_reset();
    hold_busy = 1'b0;
    check_val("sat_reset_clears", 32'(drop_count), 32'd0);
  endtask

  task automatic test_flush();
    bit flush_on;
`ifdef NONCE_FLUSH_ON_LOAD_EN
    flush_on = 1'b1;
`else
    flush_on = 1'b0;
`endif
    do_reset();
    sends = 0;
    nonce_in[0 +: 32] = 32'h4000;
    exp_q.push_back(32'h4000);
    for (int i = 1; i < 4; i++) begin
      nonce_in[32*i +: 32] = 32'h4000 + 32'(i);
      if (!flush_on) exp_q.push_back(32'h4000 + 32'(i));
    end
    nonce_valid = 6'b001111;
    step();
    nonce_valid = '0;
    for (int c = 0; c < 4; c++) step();
    check_val("flush_pre_fifo", 32'(fifo_count), 32'd3);
    load_flag = ~load_flag;
    step();
    check_val("flush_fifo_after_toggle", 32'(fifo_count), flush_on ? 32'd0 : 32'd3);
    wait_idle(400, "flush");
    check_val("flush_sends", 32'(sends), flush_on ? 32'd1 : 32'd4);
    check_val("flush_drop_count", 32'(drop_count), 32'd0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    sends = 0;
    nonce_in[0 +: 32] = 32'h5000;
    nonce_in[32 +: 32] = 32'h5001;
    nonce_in[64 +: 32] = 32'h5002;
    exp_q.push_back(32'h5000);
    nonce_valid = 6'b000111;
    step();
    nonce_valid = '0;
    for (int c = 0; c < 4; c++) step();
    check_val("mid_pre_fifo", 32'(fifo_count), 32'd2);
    check_val("mid_pre_busy", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("mid_fifo_count", 32'(fifo_count), 32'd0);
    check_val("mid_tx_send", 32'(tx_send), 32'd0);
    check_val("mid_idle", 32'(idle), 32'd1);
    check_val("mid_drop_count", 32'(drop_count), 32'd0);
    wait_idle(100, "mid");
    check_val("mid_sends", 32'(sends), 32'd1);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    sends       = 0;
    prev_send   = 1'b0;
    reset       = 1'b1;
    nonce_valid = '0;
    nonce_in    = '0;
    load_flag   = 1'b0;
    hold_busy   = 1'b0;
    model_busy  = 1'b0;
    busy_left   = 0;
    step();
    test_reset();
    test_single();
    test_round_robin();
    test_capture_on_drain();
    test_overrun();
    test_saturation();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
